// File: rtl/error_code_blinker.sv
// Error indicator: validates the mode switch bank on a confirm press, accepts external
// error requests, and blinks the error code on one LED for a fixed window.
module error_code_blinker #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BLINK_HZ    = 4,
    parameter int ERROR_MS    = 1000,
    parameter int SW_WIDTH    = 5,
    parameter int CODE_W      = 3,
    parameter int GAP_HALVES  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_pulse,
    input  logic [SW_WIDTH-1:0]         mode_sw,
    input  logic [2:0]                  mode_state,
    input  logic                        ext_err_req,
    input  logic [CODE_W-1:0]           ext_err_code,
    input  logic                        clear,
    output logic                        error_active,
    output logic [CODE_W-1:0]           error_code,
    output logic                        blink_bit,
    output logic                        sel_valid,
    output logic [$clog2(SW_WIDTH)-1:0] sel_index
);

    // state | meaning
    // IDLE  | no error; presses are checked, selections reported
    // ON    | LED lit for one half period
    // OFF   | LED dark for one half period, then count the pulse
    // GAP   | LED dark between code bursts
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    localparam int          IDX_W   = $clog2(SW_WIDTH);
    localparam logic [31:0] HALF    = 32'(CLK_FREQ_HZ / (BLINK_HZ * 2));
    localparam logic [31:0] GAP_LEN = 32'(GAP_HALVES * (CLK_FREQ_HZ / (BLINK_HZ * 2)));
    localparam logic [31:0] WIN     = 32'((CLK_FREQ_HZ / 1000) * ERROR_MS);

    state_t              state_q;
    logic                active_q;
    logic [CODE_W-1:0]   code_q;
    logic                blink_q;
    logic                sel_valid_q;
    logic [IDX_W-1:0]    sel_index_q;
    logic [31:0]         phase_q;
    logic [31:0]         win_q;
    logic [CODE_W-1:0]   pulse_q;

    logic [4:0]          ones;
    logic [IDX_W-1:0]    hot_idx;
    logic                local_req;
    logic [CODE_W-1:0]   local_code;
    logic                local_err;
    logic                ext_ok;
    logic [CODE_W-1:0]   trig_code;
    logic                sel_ok;

    always_comb begin
        ones    = '0;
        hot_idx = '0;
        for (int i = 0; i < SW_WIDTH; i++) begin
            if (mode_sw[i]) begin
                ones    = ones + 5'd1;
                hot_idx = IDX_W'(i);
            end
        end
    end

    assign local_req  = btn_pulse && (mode_state == 3'd0);
    assign local_code = (ones == 5'd0) ? CODE_W'(1) : (ones > 5'd1) ? CODE_W'(2) : '0;
    assign local_err  = local_req && (local_code != '0);
    assign ext_ok     = ext_err_req && (ext_err_code != '0);
    assign trig_code  = local_err ? local_code : ext_err_code;
    // An error starting next cycle suppresses the selection so sel_valid never overlaps it
    assign sel_ok     = local_req && !local_err && !ext_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            active_q    <= 1'b0;
            code_q      <= '0;
            blink_q     <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_index_q <= '0;
            phase_q     <= '0;
            win_q       <= '0;
            pulse_q     <= '0;
        end else begin
            sel_valid_q <= 1'b0;
            if (clear || (state_q != S_IDLE && win_q == '0)) begin
                state_q  <= S_IDLE;
                active_q <= 1'b0;
                code_q   <= '0;
                blink_q  <= 1'b0;
                phase_q  <= '0;
                win_q    <= '0;
                pulse_q  <= '0;
            end else if (state_q == S_IDLE) begin
                if (local_err || ext_ok) begin
                    state_q  <= S_ON;
                    active_q <= 1'b1;
                    code_q   <= trig_code;
                    blink_q  <= 1'b1;
                    phase_q  <= HALF - 32'd1;
                    win_q    <= WIN - 32'd1;
                    pulse_q  <= '0;
                end else if (sel_ok) begin
                    sel_valid_q <= 1'b1;
                    sel_index_q <= hot_idx;
                end
            end else begin
                win_q <= win_q - 32'd1;
                if (phase_q != '0) begin
                    phase_q <= phase_q - 32'd1;
                end else begin
                    case (state_q)
                        S_ON: begin
                            state_q <= S_OFF;
                            blink_q <= 1'b0;
                            phase_q <= HALF - 32'd1;
                        end
                        S_OFF: begin
                            pulse_q <= pulse_q + 1'b1;
                            if ((pulse_q + 1'b1) == code_q) begin
                                state_q <= S_GAP;
                                phase_q <= GAP_LEN - 32'd1;
                            end else begin
                                state_q <= S_ON;
                                blink_q <= 1'b1;
                                phase_q <= HALF - 32'd1;
                            end
                        end
                        S_GAP: begin
                            state_q <= S_ON;
                            blink_q <= 1'b1;
                            pulse_q <= '0;
                            phase_q <= HALF - 32'd1;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign error_active = active_q;
    assign error_code   = code_q;
    assign blink_bit    = blink_q;
    assign sel_valid    = sel_valid_q;
    assign sel_index    = sel_index_q;

endmodule

// File: tb/tb_error_code_blinker.sv
// Bench for error_code_blinker: single-cycle vector table plus full-window blink sequences.
module tb_error_code_blinker;

    localparam int H          = 10;
    localparam int W          = 1000;
    localparam int GAP_HALVES = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_pulse;
    logic [4:0] mode_sw;
    logic [2:0] mode_state;
    logic       ext_err_req;
    logic [2:0] ext_err_code;
    logic       clear;
    logic       error_active;
    logic [2:0] error_code;
    logic       blink_bit;
    logic       sel_valid;
    logic [2:0] sel_index;

    error_code_blinker #(
        .CLK_FREQ_HZ(1000),
        .BLINK_HZ   (50),
        .ERROR_MS   (1000),
        .SW_WIDTH   (5),
        .CODE_W     (3),
        .GAP_HALVES (GAP_HALVES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pulse   (btn_pulse),
        .mode_sw     (mode_sw),
        .mode_state  (mode_state),
        .ext_err_req (ext_err_req),
        .ext_err_code(ext_err_code),
        .clear       (clear),
        .error_active(error_active),
        .error_code  (error_code),
        .blink_bit   (blink_bit),
        .sel_valid   (sel_valid),
        .sel_index   (sel_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic [4:0] sw;
        logic [2:0] ms;
        logic       ext;
        logic [2:0] ecode;
        logic       clr;
        logic [8:0] exp;
    } vec_t;

    vec_t       tbl[16];
    logic [8:0] sb_q[$];
    int         n_vec;
    int         n_fail;

    // Output word layout: {error_active, error_code, blink_bit, sel_valid, sel_index}
    function automatic logic [8:0] pk(input logic a, input logic [2:0] c, input logic b,
                                      input logic s, input logic [2:0] i);
        return {a, c, b, s, i};
    endfunction

    function automatic logic [8:0] outs();
        return {error_active, error_code, blink_bit, sel_valid, sel_index};
    endfunction

    function automatic vec_t mk(input logic btn, input logic [4:0] sw, input logic [2:0] ms,
                                input logic ext, input logic [2:0] ecode, input logic clr,
                                input logic [8:0] exp);
        vec_t v;
        v.btn = btn; v.sw = sw; v.ms = ms; v.ext = ext; v.ecode = ecode; v.clr = clr; v.exp = exp;
        return v;
    endfunction

    // Expected outputs k cycles after the trigger edge (k = 1 is the trigger edge itself)
    function automatic logic [8:0] exp_err(input int k, input int code, input logic [2:0] idx);
        int   p;
        int   ph;
        logic b;
        if (k > W) return pk(1'b0, 3'd0, 1'b0, 1'b0, idx);
        p  = (2 * code + GAP_HALVES) * H;
        ph = (k - 1) % p;
        b  = (ph < 2 * code * H) && (((ph / H) % 2) == 0);
        return pk(1'b1, 3'(code), b, 1'b0, idx);
    endfunction

    task automatic cmp_now(input string tag, input logic [8:0] exp);
        n_vec++;
        if (outs() !== exp) begin
            n_fail++;
            $display("FAIL %s: got %09b want %09b", tag, outs(), exp);
        end
    endtask

    task automatic check_sb(input string tag, input int k);
        logic [8:0] exp;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %09b want <scoreboard empty>", tag, k, outs());
        end else begin
            exp = sb_q.pop_front();
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL %s k=%0d: got %09b want %09b", tag, k, outs(), exp);
            end
        end
    endtask

    task automatic idle_inputs();
        btn_pulse    = 1'b0;
        ext_err_req  = 1'b0;
        ext_err_code = 3'd0;
        clear        = 1'b0;
    endtask

    // Trigger inputs are set by the caller; they are sampled on the edge of k = 1.
    task automatic run_window(input string tag, input int code, input logic [2:0] idx,
                              input int retrig_k, input logic [4:0] retrig_sw,
                              input int clear_k, input int stop_k);
        for (int k = 1; k <= stop_k; k++) begin
            if (k == retrig_k) begin
                btn_pulse    = 1'b1;
                mode_sw      = retrig_sw;
                mode_state   = 3'd0;
                ext_err_req  = 1'b1;
                ext_err_code = 3'd7;
            end
            if (k == clear_k) clear = 1'b1;
            if (clear_k > 0 && k >= clear_k)
                sb_q.push_back(pk(1'b0, 3'd0, 1'b0, 1'b0, idx));
            else
                sb_q.push_back(exp_err(k, code, idx));
            @(posedge clk);
            #1;
            idle_inputs();
            check_sb(tag, k);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        mode_sw    = '0;
        mode_state = '0;
        idle_inputs();
        n_vec  = 0;
        n_fail = 0;

        //           btn   sw        ms    ext   ecode clr   {act code blink sv idx}
        tbl[0]  = mk(1'b1, 5'b00100, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b1, 3'd2));
        tbl[1]  = mk(1'b1, 5'b00001, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b1, 3'd0));
        tbl[2]  = mk(1'b1, 5'b10000, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b1, 3'd4));
        tbl[3]  = mk(1'b1, 5'b00000, 3'd1, 1'b0, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
        tbl[4]  = mk(1'b0, 5'b00000, 3'd0, 1'b1, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
        tbl[5]  = mk(1'b1, 5'b00110, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b1, 3'd2, 1'b1, 1'b0, 3'd4));
        tbl[6]  = mk(1'b1, 5'b00000, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b1, 3'd1, 1'b1, 1'b0, 3'd4));
        tbl[7]  = mk(1'b1, 5'b00000, 3'd0, 1'b1, 3'd5, 1'b0, pk(1'b1, 3'd1, 1'b1, 1'b0, 3'd4));
        tbl[8]  = mk(1'b0, 5'b00000, 3'd0, 1'b1, 3'd3, 1'b0, pk(1'b1, 3'd3, 1'b1, 1'b0, 3'd4));
        tbl[9]  = mk(1'b1, 5'b00110, 3'd2, 1'b1, 3'd6, 1'b0, pk(1'b1, 3'd6, 1'b1, 1'b0, 3'd4));
        tbl[10] = mk(1'b1, 5'b01000, 3'd0, 1'b0, 3'd0, 1'b1, pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
        tbl[11] = mk(1'b0, 5'b00000, 3'd0, 1'b1, 3'd4, 1'b1, pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
        tbl[12] = mk(1'b1, 5'b11111, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b1, 3'd2, 1'b1, 1'b0, 3'd4));
        tbl[13] = mk(1'b1, 5'b01000, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b1, 3'd3));
        tbl[14] = mk(1'b1, 5'b00011, 3'd0, 1'b0, 3'd0, 1'b0, pk(1'b1, 3'd2, 1'b1, 1'b0, 3'd3));
        tbl[15] = mk(1'b1, 5'b00010, 3'd7, 1'b0, 3'd0, 1'b0, pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd3));

        repeat (3) @(posedge clk);
        #1;
        cmp_now("reset_hold", pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_now("reset_release", pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0));

        for (int v = 0; v < 16; v++) begin
            btn_pulse    = tbl[v].btn;
            mode_sw      = tbl[v].sw;
            mode_state   = tbl[v].ms;
            ext_err_req  = tbl[v].ext;
            ext_err_code = tbl[v].ecode;
            clear        = tbl[v].clr;
            sb_q.push_back(tbl[v].exp);
            @(posedge clk);
            #1;
            idle_inputs();
            mode_state = 3'd0;
            check_sb($sformatf("vec%0d", v), v);
            clear = 1'b1;
            sb_q.push_back(pk(1'b0, 3'd0, 1'b0, 1'b0, tbl[v].exp[2:0]));
            @(posedge clk);
            #1;
            clear = 1'b0;
            check_sb($sformatf("vec%0d_clr", v), v);
        end

        // Code 2 burst pattern over a whole window, then drop to idle
        mode_sw    = 5'b00110;
        mode_state = 3'd0;
        btn_pulse  = 1'b1;
        run_window("code2_win", 2, 3'd3, 0, 5'b00000, 0, W + 3);

        // Local error beats a simultaneous external request; a press at 300 does not restart
        mode_sw      = 5'b00000;
        btn_pulse    = 1'b1;
        ext_err_req  = 1'b1;
        ext_err_code = 3'd5;
        run_window("prio_win", 1, 3'd3, 300, 5'b00000, 0, W + 3);

        // Clear mid-burst
        ext_err_req  = 1'b1;
        ext_err_code = 3'd3;
        run_window("clear_win", 3, 3'd3, 0, 5'b00000, 56, 60);

        // Asynchronous reset mid-window, then a fresh full window
        ext_err_req  = 1'b1;
        ext_err_code = 3'd3;
        run_window("rst_win", 3, 3'd3, 0, 5'b00000, 0, 500);
        #2 rst_n = 1'b0;
        #1 cmp_now("async_rst", pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_now("post_rst", pk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0));
        ext_err_req  = 1'b1;
        ext_err_code = 3'd3;
        run_window("full_win", 3, 3'd0, 123, 5'b00001, 0, W + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
